// File: rtl/dmem_if.sv
// Request / memory / response bundle for the data-memory controller.
interface dmem_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] req_wdata;
  logic [2:0]         req_addrmode;
  logic               mem_req;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [3:0]         mem_be;
  logic               mem_ack;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [D_WIDTH-1:0] ramout;
  logic [2:0]         addrmode;
  logic [1:0]         selectbytes;
  logic               misaligned;
  logic               bus_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_addrmode, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           rsp_valid, ramout, addrmode, selectbytes, misaligned, bus_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_addrmode, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           rsp_valid, ramout, addrmode, selectbytes, misaligned, bus_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller: lane positioning, misalignment
// trap, bounded wait for mem_ack, and a held response for the load formatter.
module dmem_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q, ramout_q;
  logic [3:0]         be_q;
  logic [2:0]         mode_q;
  logic [1:0]         sel_q;
  logic               we_q, mis_q, berr_q;
  logic [7:0]         cnt_q;

  logic       accept, mis, timeout;
  logic [1:0] off;
  logic [3:0] be;

  assign off     = bus.req_addr[1:0];
  assign accept  = bus.req_valid & bus.req_ready;
  // ack on the last allowed cycle takes priority over the timeout
  assign timeout = (cnt_q == 8'(TIMEOUT - 1)) & ~bus.mem_ack;

  always_comb begin
    mis = 1'b0;
    be  = 4'b1111;
    case (bus.req_addrmode[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01: begin
        be  = 4'b0011 << off;
        mis = (off == 2'd3);
      end
      default: mis = (off != 2'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mis ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || timeout) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.mem_req   = (state_q == ACCESS);
    bus.mem_we    = (state_q == ACCESS) & we_q;
    bus.rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      ramout_q <= '0;
      be_q     <= '0;
      mode_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q   <= {bus.req_addr[A_WIDTH-1:2], 2'b00};
          sel_q    <= off;
          mode_q   <= bus.req_addrmode;
          we_q     <= bus.req_we;
          be_q     <= bus.req_we ? be : 4'b1111;
          wdata_q  <= bus.req_we ? (bus.req_wdata << {off, 3'b000}) : '0;
          cnt_q    <= '0;
          ramout_q <= '0;
          mis_q    <= mis;
          berr_q   <= 1'b0;
        end
        ACCESS: begin
          if (bus.mem_ack)  ramout_q <= we_q ? '0 : bus.mem_rdata;
          else if (timeout) berr_q   <= 1'b1;
          else              cnt_q    <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_be      = be_q;
  assign bus.ramout      = ramout_q;
  assign bus.addrmode    = mode_q;
  assign bus.selectbytes = sel_q;
  assign bus.misaligned  = mis_q;
  assign bus.bus_err     = berr_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed + random load/store transactions against a lane/timeout reference model.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic clk, rst_n;
  int   checks = 0, failures = 0;

  dmem_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();
  dmem_ctrl #(.D_WIDTH(32), .A_WIDTH(32), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction from accept to response handshake; ackd >= TO means no ack.
  task automatic run(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] mode, input int ackd, input int rspd,
                     input logic [31:0] rd);
    int nb, off, n;
    bit mis, berr;
    logic [3:0]  ebe;
    logic [31:0] ewd, eram, eaddr;
    off   = int'(addr[1:0]);
    nb    = mode[1] ? 4 : (mode[0] ? 2 : 1);
    mis   = (nb == 2 && off == 3) || (nb == 4 && off != 0);
    berr  = !mis && (ackd >= TO);
    eaddr = addr & 32'hFFFF_FFFC;
    ebe   = 4'b0;
    for (int i = 0; i < 4; i++)
      if (!we || (i >= off && i < off + nb)) ebe[i] = 1'b1;
    ewd  = we ? (wd << (8 * off)) : 32'h0;
    eram = (mis || berr || we) ? 32'h0 : rd;

    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_addrmode = mode;
    cyc();
    bus.req_valid = 1'b0; bus.req_we = $urandom_range(0, 1); bus.req_addr = $urandom;
    bus.req_wdata = $urandom; bus.req_addrmode = 3'($urandom_range(0, 7));

    if (!mis) begin
      n = 0;
      while (bus.mem_req === 1'b1 && n < 20) begin
        chk("mem_addr", bus.mem_addr, eaddr);
        chk("mem_be", {28'b0, bus.mem_be}, {28'b0, ebe});
        chk("mem_wdata", bus.mem_wdata, ewd);
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
        bus.mem_ack   = (n == ackd);
        bus.mem_rdata = (n == ackd) ? rd : $urandom;
        cyc();
        n++;
      end
      bus.mem_ack = 1'b0;
      chk("mem_req_cycles", n, (ackd < TO) ? ackd + 1 : TO);
    end else begin
      chk("mis_no_mem_req", {31'b0, bus.mem_req}, 32'd0);
    end

    for (int k = 0; k <= rspd; k++) begin
      chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
      chk("ramout", bus.ramout, eram);
      chk("addrmode", {29'b0, bus.addrmode}, {29'b0, mode});
      chk("selectbytes", {30'b0, bus.selectbytes}, 32'(off));
      chk("misaligned", {31'b0, bus.misaligned}, {31'b0, mis});
      chk("bus_err", {31'b0, bus.bus_err}, {31'b0, berr});
      bus.mem_ack   = $urandom_range(0, 1);
      bus.mem_rdata = $urandom;
      bus.rsp_ready = (k == rspd);
      cyc();
    end
    bus.rsp_ready = 1'b0;
    bus.mem_ack   = 1'b0;
    chk("rsp_valid_fall", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] modes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int n;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_addrmode = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
    chk("rst_ramout", bus.ramout, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    cyc();

    run(1'b1, 32'h0000_1002, 32'h0000_00AB, 3'b000, 0, 0, 32'h0);
    chk("sb_ramout_after", bus.ramout, 32'h0);
    run(1'b0, 32'h0000_2001, 32'h0, 3'b001, 0, 0, 32'h12F0_E0D0);
    run(1'b0, 32'h0000_3002, 32'h0, 3'b010, 0, 0, 32'hDEAD_BEEF);
    run(1'b0, 32'h0000_4000, 32'h0, 3'b010, 100, 0, 32'hCAFE_F00D);
    run(1'b0, 32'h0000_5000, 32'h0, 3'b010, TO - 1, 0, 32'h5555_AAAA);
    run(1'b1, 32'h0000_6003, 32'hFFFF_FF77, 3'b001, 1, 3, 32'h0);
    run(1'b1, 32'h0000_7002, 32'h1234_5678, 3'b101, 2, 0, 32'h0);
    run(1'b0, 32'h0000_8000, 32'h0, 3'b010, 0, 3, 32'h0BAD_F00D);

    for (int t = 0; t < 40; t++)
      run($urandom_range(0, 1), $urandom, $urandom, modes[$urandom_range(0, 4)],
          $urandom_range(0, 5), $urandom_range(0, 3), $urandom);

    // reset pulsed while waiting for an ack
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0000_9000; bus.req_addrmode = 3'b010;
    cyc();
    bus.req_valid = 1'b0;
    chk("pre_rst_mem_req", {31'b0, bus.mem_req}, 32'd1);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      cyc();
      if (bus.rsp_valid !== 1'b0 || bus.mem_req !== 1'b0) n++;
    end
    chk("post_rst_quiet", n, 0);
    run(1'b0, 32'h0000_A004, 32'h0, 3'b100, 0, 0, 32'h89AB_CDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 32: data width; only 32 is supported.
REQ-002 Parameter A_WIDTH, default 32: byte-address width.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for mem_ack; legal range 1..255.
REQ-004 Clock and reset SHALL be one clock and an asynchronous, active-low reset, with the ports listed first as follows.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  access request valid.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  A_WIDTH  byte address.
REQ-011 req_wdata  in  D_WIDTH  store data, right-aligned.
REQ-012 req_addrmode  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 mem_req / mem_we  out  1 each  memory strobe and write enable.
REQ-014 mem_addr  out  A_WIDTH  word-aligned address, bits [1:0] = 0.
REQ-015 mem_wdata  out  D_WIDTH  lane-positioned store data.
REQ-016 mem_be  out  4  byte enables; bit i enables bits [8i+7:8i].
REQ-017 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-018 mem_rdata  in  D_WIDTH  raw memory word.
REQ-019 rsp_valid  out  1  response valid; rsp_ready  in  1  consumer accepts the response.
REQ-020 ramout  out  D_WIDTH  raw captured word, fed to the load formatter.
REQ-021 addrmode  out  3; selectbytes  out  2  registered req_addrmode and req_addr[1:0].
REQ-022 misaligned / bus_err  out  1 each  response error flags.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS and RESP; req_ready = 1 only in IDLE.
REQ-024 A request is accepted on a cycle where req_valid = 1 and req_ready = 1; all request fields are registered on that cycle.
REQ-025 Size SHALL be taken from addrmode[1:0]: 00 byte, 01 half, 10 or 11 word; addrmode[2] is ignored for stores.
REQ-026 Misalignment rules: a half access at offset 3 is misaligned; a word access at a nonzero offset is misaligned.
REQ-027 On a misaligned request: IDLE->RESP with no mem_req, misaligned = 1, ramout = 0.
REQ-028 On an aligned request: IDLE->ACCESS.
REQ-029 In ACCESS: mem_req = 1, mem_addr = {addr[A_WIDTH-1:2], 2'b00}, mem_we = req_we; all are held stable until mem_ack.
REQ-030 Store byte enables: byte = 1<<off; half = 4'b0011<<off; word = 4'b1111.
REQ-031 Store data: mem_wdata = req_wdata << (8*off), with bits shifted out discarded.
REQ-032 For loads, mem_be = 4'b1111 and mem_wdata = 0.
REQ-033 When mem_ack = 1 in ACCESS: capture mem_rdata into ramout for loads (0 for stores), then ACCESS->RESP.
REQ-034 mem_ack outside ACCESS SHALL be ignored.
REQ-035 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without mem_ack.
REQ-036 When the wait counter reaches TIMEOUT: drop mem_req, set bus_err = 1, ramout = 0, ACCESS->RESP.
REQ-037 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and bus_err = 0.
REQ-038 In RESP: rsp_valid = 1, and ramout, addrmode, selectbytes and the error flags are held stable until rsp_ready = 1, then RESP->IDLE.
REQ-039 rsp_valid SHALL fall, and req_ready rise, in the cycle after the response handshake.
REQ-040 Minimum aligned latency: accept at cycle N, mem_req at N+1, ack at N+1, rsp_valid at N+2.
REQ-041 Minimum misaligned latency: accept at cycle N, rsp_valid at N+1.
REQ-042 Stores SHALL produce a response like loads, with ramout = 0.

Reset
REQ-043 rst_n = 0 SHALL force IDLE immediately, including mid-ACCESS or mid-RESP; no pending response survives reset.
REQ-044 During reset: mem_req, mem_we, rsp_valid, misaligned, bus_err = 0; mem_addr, mem_wdata, ramout, addrmode, selectbytes, mem_be and the wait counter = 0; req_ready = 1.

Verification
REQ-045 Byte store, addr 0x1002, wdata 0x000000AB, ack on the first cycle -> mem_addr 0x1000, mem_be 0100, mem_wdata 0x00AB0000, rsp_valid at N+2.
REQ-046 LH at addr 0x2001, mem_rdata 0x12F0E0D0 -> ramout 0x12F0E0D0, addrmode 001, selectbytes 01, misaligned 0.
REQ-047 LW at addr 0x3002 -> no mem_req, rsp_valid at N+1, misaligned 1, ramout 0.
REQ-048 Load with mem_ack never asserted, TIMEOUT = 4 -> mem_req high exactly 4 cycles, bus_err 1, ramout 0.
REQ-049 rsp_ready held low for 3 cycles -> response outputs stable and req_ready 0 throughout; after the handshake, a back-to-back request is accepted the next cycle.
REQ-050 rst_n pulsed low mid-ACCESS -> mem_req drops asynchronously, req_ready 1, and no rsp_valid follows.
